// File: rtl/j1_dstack.sv
// j1_dstack -- parametrised stack for J1-family cores.
//
// Holds every entry below the core's top-of-stack register. The core's 2-bit
// signed stack delta is consumed directly; the top two entries are presented
// combinationally from registered state.
//
// Parameters:
//   WIDTH  entry width in bits (>=1)
//   DEPTH  number of entries (>=2)
//   DW     width of the depth output (derived; leave at default)
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   reset    in   asynchronous active-high reset
//   delta    in   stack delta: 00 hold, 01 push, 11 pop 1, 10 pop 2
//   in       in   data written on push or overwrite
//   wr       in   overwrite top entry with `in` (only when delta==00)
//   clr_err  in   clear sticky error flags (a same-cycle new error wins)
//   st1      out  top entry, 0 when empty
//   st2      out  entry below top, 0 when fewer than two entries
//   depth    out  number of valid entries, 0..DEPTH
//   ovf      out  sticky overflow flag
//   unf      out  sticky underflow flag
module j1_dstack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       delta,
  input  logic [WIDTH-1:0] in,
  input  logic             wr,
  input  logic             clr_err,
  output logic [WIDTH-1:0] st1,
  output logic [WIDTH-1:0] st2,
  output logic [DW-1:0]    depth,
  output logic             ovf,
  output logic             unf
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  localparam logic [1:0] D_HOLD = 2'b00;
  localparam logic [1:0] D_PUSH = 2'b01;
  localparam logic [1:0] D_POP2 = 2'b10;
  localparam logic [1:0] D_POP1 = 2'b11;

  // Explicit wrap so that non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? LAST : p - PW'(1);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] sp_q, sp_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          ovf_set, unf_set;
  logic          we;
  logic [PW-1:0] wa;
  logic [PW-1:0] sp_below;

  assign sp_below = ptr_dec(sp_q);

  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    we      = 1'b0;
    wa      = sp_q;
    case (delta)
      D_HOLD: begin
        if (wr) begin
          we = 1'b1;
          // Overwriting an empty stack behaves like a push into slot sp.
          if (depth_q == '0) begin
            depth_d = DW'(1);
          end
        end
      end
      D_PUSH: begin
        sp_d = ptr_inc(sp_q);
        we   = 1'b1;
        wa   = ptr_inc(sp_q);
        // When full the pointer lands on the oldest entry, so it is dropped.
        if (depth_q == FULL) begin
          ovf_set = 1'b1;
        end else begin
          depth_d = depth_q + DW'(1);
        end
      end
      D_POP1: begin
        if (depth_q == '0) begin
          unf_set = 1'b1;
        end else begin
          sp_d    = sp_below;
          depth_d = depth_q - DW'(1);
        end
      end
      default: begin // D_POP2
        if (depth_q >= DW'(2)) begin
          sp_d    = ptr_dec(sp_below);
          depth_d = depth_q - DW'(2);
        end else if (depth_q == DW'(1)) begin
          sp_d    = sp_below;
          depth_d = '0;
          unf_set = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
    endcase

    // Set wins over clear.
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    unf_d = unf_set | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held so an
  // in-flight operation cannot leave stale data behind.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[wa] <= in;
    end
  end

  assign st1   = (depth_q != '0)     ? mem[sp_q]     : '0;
  assign st2   = (depth_q >= DW'(2)) ? mem[sp_below] : '0;
  assign depth = depth_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_j1_dstack.sv
// Self-checking bench for j1_dstack (DEPTH=4). A queue-based model of the
// stack is compared against the DUT on every falling edge, plus literal
// expectations from hand-worked scenarios.
module tb_j1_dstack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic [1:0]       delta;
  logic [WIDTH-1:0] din;
  logic             wr;
  logic             clr_err;
  logic [WIDTH-1:0] st1;
  logic [WIDTH-1:0] st2;
  logic [DW-1:0]    depth;
  logic             ovf;
  logic             unf;

  j1_dstack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .delta   (delta),
    .in      (din),
    .wr      (wr),
    .clr_err (clr_err),
    .st1     (st1),
    .st2     (st2),
    .depth   (depth),
    .ovf     (ovf),
    .unf     (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: queue with the oldest entry at the front, top at the back.
  logic [WIDTH-1:0] mq[$];
  bit               movf;
  bit               munf;
  bit               model_valid;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int exp_st1();
    return (mq.size() > 0) ? int'(mq[mq.size()-1]) : 0;
  endfunction

  function automatic int exp_st2();
    return (mq.size() > 1) ? int'(mq[mq.size()-2]) : 0;
  endfunction

  task automatic model_step(input logic [1:0] d, input logic w,
                            input logic [WIDTH-1:0] v, input logic c);
    bit so = 0;
    bit su = 0;
    case (d)
      2'b00: if (w) begin
        if (mq.size() == 0) mq.push_back(v);
        else mq[mq.size()-1] = v;
      end
      2'b01: begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          so = 1;
        end
        mq.push_back(v);
      end
      2'b11: begin
        if (mq.size() == 0) su = 1;
        else void'(mq.pop_back());
      end
      default: begin
        if (mq.size() >= 2) begin
          void'(mq.pop_back());
          void'(mq.pop_back());
        end else if (mq.size() == 1) begin
          void'(mq.pop_back());
          su = 1;
        end else begin
          su = 1;
        end
      end
    endcase
    if (c) begin
      movf = so;
      munf = su;
    end else begin
      movf = movf | so;
      munf = munf | su;
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset && model_valid) begin
      check("st1",   int'(st1),   exp_st1());
      check("st2",   int'(st2),   exp_st2());
      check("depth", int'(depth), mq.size());
      check("ovf",   int'(ovf),   int'(movf));
      check("unf",   int'(unf),   int'(munf));
    end
  end

  // One operation: drive from the falling edge, clock it, update model.
  task automatic op(input logic [1:0] d, input logic w,
                    input logic [WIDTH-1:0] v, input logic c);
    delta   = d;
    wr      = w;
    din     = v;
    clr_err = c;
    @(posedge clk);
    model_step(d, w, v, c);
    $display("op delta=%b wr=%b in=0x%0h clr=%b -> model depth=%0d st1=0x%0h",
             d, w, v, c, mq.size(), exp_st1());
    @(negedge clk);
    delta   = 2'b00;
    wr      = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    op(2'b01, 1'b0, v, 1'b0);
  endtask

  // Assert reset in the middle of the low phase, verify outputs clear
  // without a clock edge, then release just after a falling edge.
  task automatic do_reset(input bit chk);
    #2 reset = 1'b1;
    #1;
    if (chk) begin
      check("rst_st1",   int'(st1),   0);
      check("rst_st2",   int'(st2),   0);
      check("rst_depth", int'(depth), 0);
      check("rst_ovf",   int'(ovf),   0);
      check("rst_unf",   int'(unf),   0);
    end
    mq.delete();
    movf = 0;
    munf = 0;
    @(negedge clk);
    #1 reset = 1'b0;
    $display("reset applied");
  endtask

  initial begin
    reset   = 1'b1;
    delta   = 2'b00;
    wr      = 1'b0;
    din     = '0;
    clr_err = 1'b0;
    model_valid = 0;
    movf = 0;
    munf = 0;
    #1;
    check("por_depth", int'(depth), 0);
    check("por_st1",   int'(st1),   0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    model_valid = 1;

    // Basic pushes.
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    check("t1_depth", int'(depth), 3);
    check("t1_st1",   int'(st1),   'h3333);
    check("t1_st2",   int'(st2),   'h2222);
    check("t1_flags", int'({ovf, unf}), 0);

    // Overflow wrap at DEPTH=4.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) push(WIDTH'(16'hA0 + i));
    check("t2_depth", int'(depth), 4);
    check("t2_ovf",   int'(ovf),   1);
    check("t2_st1",   int'(st1),   'hA4);
    for (int i = 0; i < 3; i++) op(2'b11, 1'b0, '0, 1'b0);
    check("t2_last_st1", int'(st1),   'hA1);
    check("t2_last_dep", int'(depth), 1);
    op(2'b11, 1'b0, '0, 1'b0);
    check("t2_empty_dep", int'(depth), 0);
    check("t2_empty_st1", int'(st1),   0);
    check("t2_no_unf",    int'(unf),   0);

    // Pop 2, including underflow from depth 1.
    do_reset(1'b0);
    push(16'h5);
    push(16'h6);
    push(16'h7);
    op(2'b10, 1'b0, '0, 1'b0);
    check("t3_st1",   int'(st1),   'h5);
    check("t3_depth", int'(depth), 1);
    op(2'b10, 1'b0, '0, 1'b0);
    check("t3_depth0", int'(depth), 0);
    check("t3_unf",    int'(unf),   1);
    check("t3_st1_0",  int'(st1),   0);

    // Overwrite and ignored wr during push.
    do_reset(1'b0);
    push(16'h10);
    op(2'b00, 1'b1, 16'h99, 1'b0);
    check("t4_st1",   int'(st1),   'h99);
    check("t4_depth", int'(depth), 1);
    op(2'b01, 1'b1, 16'h42, 1'b0);
    check("t4_push_st1", int'(st1),   'h42);
    check("t4_push_st2", int'(st2),   'h99);
    check("t4_push_dep", int'(depth), 2);
    // Overwrite on empty acts as a push.
    op(2'b10, 1'b0, '0, 1'b0);
    op(2'b00, 1'b1, 16'h77, 1'b0);
    check("t4_wr_empty_dep", int'(depth), 1);
    check("t4_wr_empty_st1", int'(st1),   'h77);
    check("t4_wr_empty_unf", int'(unf),   0);

    // Sticky flags vs clr_err.
    do_reset(1'b0);
    op(2'b11, 1'b0, '0, 1'b0);
    check("t5_unf_set", int'(unf), 1);
    op(2'b00, 1'b0, '0, 1'b0);
    check("t5_unf_sticky", int'(unf), 1);
    op(2'b00, 1'b0, '0, 1'b1);
    check("t5_unf_clr", int'(unf), 0);
    op(2'b11, 1'b0, '0, 1'b1);
    check("t5_set_wins", int'(unf), 1);

    // Async reset with a populated stack.
    do_reset(1'b0);
    push(16'hC1);
    push(16'hC2);
    push(16'hC3);
    check("t6_pre_depth", int'(depth), 3);
    do_reset(1'b1);
    // First operation after reset acts on an empty stack.
    op(2'b11, 1'b0, '0, 1'b0);
    check("t6_post_unf", int'(unf), 1);
    push(16'hD0);
    check("t6_post_st1", int'(st1), 'hD0);
    @(negedge clk);

    model_valid = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
